// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter that merges N show-ahead stream sources into one
// registered show-ahead output, giving each grant at most BURST words.
module stream_rr_arbiter #(
  parameter int unsigned W     = 8,
  parameter int unsigned N     = 2,
  parameter int unsigned BURST = 4
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [N*W-1:0] in,
  output logic [N-1:0]   get_i,
  input  logic [N-1:0]   empty_i,
  output logic [W-1:0]   out,
  input  logic           get_o,
  output logic           empty_o,
  output logic [N-1:0]   grant
);

  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CNT_W = $clog2(BURST) + 1;

  typedef enum logic {
    IDLE,
    OWN
  } state_t;

  state_t           state, state_n;
  logic [N-1:0]     grant_n;
  logic [CNT_W-1:0] count, count_n;
  logic             full, full_n;
  logic [W-1:0]     data, data_n;
  logic [IDX_W-1:0] last, last_n;
  logic [IDX_W-1:0] owner, owner_n;
  logic [IDX_W-1:0] pick;
  logic             any_req;
  logic             free;
  logic             take;

  // Pick the first non-empty source scanning upward from the one after last.
  always_comb begin
    int unsigned idx;
    pick    = last;
    any_req = 1'b0;
    idx     = 0;
    for (int unsigned i = 1; i <= N; i++) begin
      idx = (32'(last) + i) % N;
      if (!any_req && !empty_i[IDX_W'(idx)]) begin
        any_req = 1'b1;
        pick    = IDX_W'(idx);
      end
    end
  end

  // Next-state, take strobe and output-register update.
  always_comb begin
    state_n = state;
    grant_n = grant;
    count_n = count;
    full_n  = full;
    data_n  = data;
    last_n  = last;
    owner_n = owner;
    get_i   = '0;
    take    = 1'b0;
    free    = ~full | get_o;

    case (state)
      IDLE: begin
        if (any_req) begin
          state_n = OWN;
          grant_n = N'(1) << pick;
          count_n = '0;
          owner_n = pick;
        end
      end
      OWN: begin
        if (free) begin
          if (!empty_i[owner]) begin
            take         = 1'b1;
            get_i[owner] = 1'b1;
            data_n       = in[32'(owner)*W +: W];
            if (count == CNT_W'(BURST - 1)) begin
              state_n = IDLE;
              last_n  = owner;
              grant_n = '0;
              count_n = '0;
            end else begin
              count_n = count + CNT_W'(1);
            end
          end else begin
            // Owner ran dry: hand the slot back without taking a word.
            state_n = IDLE;
            last_n  = owner;
            grant_n = '0;
            count_n = '0;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // A take refills the slot even when the consumer drains it the same cycle.
    if (take) begin
      full_n = 1'b1;
    end else if (get_o && full) begin
      full_n = 1'b0;
    end

    // No source may be popped while reset is held.
    if (reset) begin
      get_i = '0;
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      grant <= '0;
      count <= '0;
      full  <= 1'b0;
      last  <= IDX_W'(N - 1);
      owner <= '0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      count <= count_n;
      full  <= full_n;
      last  <= last_n;
      owner <= owner_n;
    end
  end

  // Output data register; contents are meaningless while empty.
  always_ff @(posedge clock) begin
    data <= data_n;
  end

  assign out     = data;
  assign empty_o = ~full;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed scoreboard bench for stream_rr_arbiter (N=2/BURST=4 and N=3/BURST=1).
module tb_stream_rr_arbiter;

  logic clock = 1'b0;
  logic reset;
  logic get_o;

  logic [15:0] in_a;
  logic [1:0]  gi_a, em_a, gr_a;
  logic [7:0]  out_a;
  logic        eo_a;

  logic [23:0] in_b;
  logic [2:0]  gi_b, em_b, gr_b;
  logic [7:0]  out_b;
  logic        eo_b;

  logic [7:0] mem_a [2][16];
  int         rd_a  [2];
  int         wr_a  [2];
  logic [7:0] mem_b [3][16];
  int         rd_b  [3];
  int         wr_b  [3];

  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  stream_rr_arbiter #(.W(8), .N(2), .BURST(4)) u_a (
    .clock   (clock),
    .reset   (reset),
    .in      (in_a),
    .get_i   (gi_a),
    .empty_i (em_a),
    .out     (out_a),
    .get_o   (get_o),
    .empty_o (eo_a),
    .grant   (gr_a)
  );

  stream_rr_arbiter #(.W(8), .N(3), .BURST(1)) u_b (
    .clock   (clock),
    .reset   (reset),
    .in      (in_b),
    .get_i   (gi_b),
    .empty_i (em_b),
    .out     (out_b),
    .get_o   (get_o),
    .empty_o (eo_b),
    .grant   (gr_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Present each source model's head word and empty flag.
  task automatic drive();
    for (int k = 0; k < 2; k++) begin
      em_a[k]          = (rd_a[k] == wr_a[k]);
      in_a[k*8 +: 8]   = em_a[k] ? 8'h00 : mem_a[k][rd_a[k]];
    end
    for (int k = 0; k < 3; k++) begin
      em_b[k]          = (rd_b[k] == wr_b[k]);
      in_b[k*8 +: 8]   = em_b[k] ? 8'h00 : mem_b[k][rd_b[k]];
    end
  endtask

  task automatic push_a(input int k, input logic [7:0] v);
    mem_a[k][wr_a[k]] = v;
    wr_a[k]++;
  endtask

  task automatic push_b(input int k, input logic [7:0] v);
    mem_b[k][wr_b[k]] = v;
    wr_b[k]++;
  endtask

  // One clock: sample take strobes mid-cycle, pop sources just after the edge.
  task automatic tick();
    logic [1:0] ta;
    logic [2:0] tb3;
    @(negedge clock);
    ta  = gi_a;
    tb3 = gi_b;
    check("a get_i onehot",   32'($countones(ta) <= 1), 32'd1);
    check("a get_i on empty", 32'(ta & em_a), 32'd0);
    check("b get_i onehot",   32'($countones(tb3) <= 1), 32'd1);
    check("b get_i on empty", 32'(tb3 & em_b), 32'd0);
    @(posedge clock);
    #1;
    for (int k = 0; k < 2; k++) if (ta[k]) rd_a[k]++;
    for (int k = 0; k < 3; k++) if (tb3[k]) rd_b[k]++;
    drive();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    get_o = 1'b0;
    for (int k = 0; k < 2; k++) begin rd_a[k] = 0; wr_a[k] = 0; end
    for (int k = 0; k < 3; k++) begin rd_b[k] = 0; wr_b[k] = 0; end
    exp_a.delete();
    exp_b.delete();
    drive();
    tick();
    tick();
    check("a reset grant",   32'(gr_a), 32'd0);
    check("a reset empty_o", 32'(eo_a), 32'd1);
    check("a reset get_i",   32'(gi_a), 32'd0);
    check("b reset grant",   32'(gr_b), 32'd0);
    check("b reset empty_o", 32'(eo_b), 32'd1);
    reset = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_a.size() + exp_b.size()) != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain timeout words left", 32'(exp_a.size() + exp_b.size()), 32'd0);
  endtask

  // Scoreboard monitor: every word the consumer takes must match the queue head.
  always @(negedge clock) begin
    if (!reset && get_o && !eo_a) begin
      if (exp_a.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL a unexpected word: got 0x%0h, expected none", out_a);
      end else begin
        check("a out word", 32'(out_a), 32'(exp_a.pop_front()));
      end
    end
    if (!reset && get_o && !eo_b) begin
      if (exp_b.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL b unexpected word: got 0x%0h, expected none", out_b);
      end else begin
        check("b out word", 32'(out_b), 32'(exp_b.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] g1 [9];
    logic [2:0] g6 [12];
    g1 = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd1, 2'd1, 2'd1, 2'd0};
    g6 = '{3'd1, 3'd0, 3'd2, 3'd0, 3'd4, 3'd0, 3'd1, 3'd0, 3'd2, 3'd0, 3'd4, 3'd0};

    // Test 1: single source, burst split by one idle bubble.
    do_reset();
    get_o = 1'b1;
    for (int i = 0; i < 6; i++) begin
      push_a(0, 8'(8'h10 + i));
      exp_a.push_back(8'(8'h10 + i));
    end
    drive();
    for (int i = 0; i < 9; i++) begin
      tick();
      check("t1 grant", 32'(gr_a), 32'(g1[i]));
      if (i == 0) check("t1 empty after pick", 32'(eo_a), 32'd1);
      if (i == 1) begin
        check("t1 empty after take", 32'(eo_a), 32'd0);
        check("t1 first word", 32'(out_a), 32'h10);
      end
    end
    drain(20);

    // Test 2: two busy sources alternate in bursts of four.
    do_reset();
    get_o = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push_a(0, 8'(8'hA0 + i));
      push_a(1, 8'(8'hB0 + i));
    end
    for (int i = 0; i < 4; i++) exp_a.push_back(8'(8'hA0 + i));
    for (int i = 0; i < 4; i++) exp_a.push_back(8'(8'hB0 + i));
    for (int i = 4; i < 8; i++) exp_a.push_back(8'(8'hA0 + i));
    for (int i = 4; i < 8; i++) exp_a.push_back(8'(8'hB0 + i));
    drive();
    drain(60);

    // Test 3: source 1 runs dry after two words, source 0 takes over.
    do_reset();
    get_o = 1'b1;
    push_a(1, 8'hC0);
    push_a(1, 8'hC1);
    drive();
    tick();
    check("t3 grant src1", 32'(gr_a), 32'd2);
    for (int i = 0; i < 3; i++) push_a(0, 8'(8'hD0 + i));
    drive();
    exp_a.push_back(8'hC0);
    exp_a.push_back(8'hC1);
    for (int i = 0; i < 3; i++) exp_a.push_back(8'(8'hD0 + i));
    tick();
    tick();
    tick();
    check("t3 release after C1", 32'(gr_a), 32'd0);
    tick();
    check("t3 grant src0", 32'(gr_a), 32'd1);
    drain(20);

    // Test 4: consumer stall holds exactly one word.
    do_reset();
    get_o = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push_a(0, 8'(8'hE0 + i));
      exp_a.push_back(8'(8'hE0 + i));
    end
    drive();
    tick();
    tick();
    check("t4 empty after take", 32'(eo_a), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4 stall out",     32'(out_a), 32'hE0);
      check("t4 stall get_i",   32'(gi_a), 32'd0);
      check("t4 stall taken",   32'(rd_a[0]), 32'd1);
    end
    get_o = 1'b1;
    drain(20);

    // Test 5: reset mid-burst with a buffered word.
    do_reset();
    get_o = 1'b1;
    for (int i = 0; i < 8; i++) push_a(0, 8'(8'h70 + i));
    push_a(1, 8'h60);
    exp_a.push_back(8'h70);
    drive();
    tick();
    tick();
    tick();
    check("t5 buffered word", 32'(out_a), 32'h71);
    reset = 1'b1;
    #1;
    check("t5 get_i during reset", 32'(gi_a), 32'd0);
    tick();
    check("t5 reset empty_o", 32'(eo_a), 32'd1);
    check("t5 reset grant",   32'(gr_a), 32'd0);
    check("t5 reset get_i",   32'(gi_a), 32'd0);
    reset = 1'b0;
    for (int i = 2; i < 6; i++) exp_a.push_back(8'(8'h70 + i));
    exp_a.push_back(8'h60);
    exp_a.push_back(8'h76);
    exp_a.push_back(8'h77);
    tick();
    check("t5 src0 first", 32'(gr_a), 32'd1);
    drain(40);

    // Test 6: BURST=1, three sources rotate with one idle cycle between words.
    do_reset();
    get_o = 1'b1;
    for (int i = 0; i < 2; i++) begin
      push_b(0, 8'(8'h30 + i));
      push_b(1, 8'(8'h40 + i));
      push_b(2, 8'(8'h50 + i));
    end
    for (int i = 0; i < 2; i++) begin
      exp_b.push_back(8'(8'h30 + i));
      exp_b.push_back(8'(8'h40 + i));
      exp_b.push_back(8'(8'h50 + i));
    end
    drive();
    for (int i = 0; i < 12; i++) begin
      tick();
      check("t6 grant",   32'(gr_b), 32'(g6[i]));
      check("t6 empty_o", 32'(eo_b), (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    drain(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
